// File: rtl/div_arbiter.sv
// Two-requester arbiter in front of a shared restoring divider.
//
// Requests are granted only while the divider is idle; when both requesters
// ask at once, the one that did not win last time is served. A granted
// operation runs N restoring steps (one per cycle) and the result is
// presented for a single DONE cycle. A zero divisor skips the calculation
// and reports Res = all ones, Rem = dividend, div_by_zero = 1.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   req0, inp1_0, inp2_0     requester 0 request, dividend, divisor
//   req1, inp1_1, inp2_1     requester 1 request, dividend, divisor
//   gnt0, gnt1               combinational one-cycle operand-capture grants
//   busy                     high whenever the divider is not idle
//   done, done_id            one-cycle result-valid pulse and owning requester
//   Res, Rem, div_by_zero    registered quotient, remainder, zero-divisor flag
module div_arbiter #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0,
  input  logic [N-1:0] inp1_0,
  input  logic [N-1:0] inp2_0,
  input  logic         req1,
  input  logic [N-1:0] inp1_1,
  input  logic [N-1:0] inp2_1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [N-1:0] Res,
  output logic [N-1:0] Rem,
  output logic         div_by_zero
);

  localparam int unsigned CW = $clog2(N) + 1;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e         state_q, state_d;
  logic           last_id_q;
  logic           owner_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic [N:0]     p_q;
  logic [CW-1:0]  cnt_q;

  logic           winner;
  logic           grant;
  logic [N-1:0]   sel_a;
  logic [N-1:0]   sel_b;
  logic           sel_b_zero;
  logic [N:0]     p_shift;
  logic [N:0]     p_trial;
  logic [N:0]     p_next;
  logic [N-1:0]   a_next;
  logic           last_step;

  // Arbitration and grants
  always_comb begin
    // With both requesting, the requester that did not win last time goes next.
    winner     = (req0 && req1) ? ~last_id_q : req1;
    gnt0       = rst_n && (state_q == StIdle) && req0 && !winner;
    gnt1       = rst_n && (state_q == StIdle) && req1 && winner;
    grant      = gnt0 || gnt1;
    sel_a      = winner ? inp1_1 : inp1_0;
    sel_b      = winner ? inp2_1 : inp2_0;
    sel_b_zero = (sel_b == '0);
  end

  // One restoring division step
  always_comb begin
    p_shift = {p_q[N-1:0], a_q[N-1]};
    p_trial = p_shift - {1'b0, b_q};
    if (p_trial[N]) begin
      // Trial subtraction went negative: keep the shifted value (restore).
      p_next = p_shift;
      a_next = {a_q[N-2:0], 1'b0};
    end else begin
      p_next = p_trial;
      a_next = {a_q[N-2:0], 1'b1};
    end
    last_step = (cnt_q == CW'(N - 1));
  end

  // Next-state and status outputs
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (grant) state_d = sel_b_zero ? StDone : StCalc;
      end
      StCalc: begin
        if (last_step) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_q   <= 1'b1;
      owner_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      p_q         <= '0;
      cnt_q       <= '0;
      Res         <= '0;
      Rem         <= '0;
      div_by_zero <= 1'b0;
      done_id     <= 1'b0;
    end else begin
      if (grant) begin
        last_id_q <= winner;
        owner_q   <= winner;
        a_q       <= sel_a;
        b_q       <= sel_b;
        p_q       <= '0;
        cnt_q     <= '0;
        if (sel_b_zero) begin
          Res         <= '1;
          Rem         <= sel_a;
          div_by_zero <= 1'b1;
          done_id     <= winner;
        end
      end
      if (state_q == StCalc) begin
        a_q   <= a_next;
        p_q   <= p_next;
        // Counter stops at N, which fits in CW bits, so it never wraps.
        cnt_q <= cnt_q + 1'b1;
        if (last_step) begin
          Res         <= a_next;
          Rem         <= p_next[N-1:0];
          div_by_zero <= 1'b0;
          done_id     <= owner_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter (N = 16): scenario tasks drive requests,
// check grant timing and latency inline, and push expected results into a
// scoreboard that a monitor pops and compares on every done pulse.
module tb_div_arbiter;

  localparam int unsigned N = 16;

  logic         clk;
  logic         rst_n;
  logic         req0;
  logic [N-1:0] inp1_0;
  logic [N-1:0] inp2_0;
  logic         req1;
  logic [N-1:0] inp1_1;
  logic [N-1:0] inp2_1;
  logic         gnt0;
  logic         gnt1;
  logic         busy;
  logic         done;
  logic         done_id;
  logic [N-1:0] Res;
  logic [N-1:0] Rem;
  logic         div_by_zero;

  typedef struct {
    logic [N-1:0] res;
    logic [N-1:0] rem;
    logic         dbz;
    logic         id;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  div_arbiter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0        (req0),
    .inp1_0      (inp1_0),
    .inp2_0      (inp2_0),
    .req1        (req1),
    .inp1_1      (inp1_1),
    .inp2_1      (inp2_1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .busy        (busy),
    .done        (done),
    .done_id     (done_id),
    .Res         (Res),
    .Rem         (Rem),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic id);
    exp_t e;
    if (b == '0) begin
      e.res = '1;
      e.rem = a;
      e.dbz = 1'b1;
    end else begin
      e.res = a / b;
      e.rem = a % b;
      e.dbz = 1'b0;
    end
    e.id = id;
    return e;
  endfunction

  // Scoreboard monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done=1 Res=%h Rem=%h, required no done", Res, Rem);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (Res !== e.res || Rem !== e.rem || div_by_zero !== e.dbz || done_id !== e.id) begin
          errors++;
          $display("FAIL result: got Res=%h Rem=%h dbz=%b id=%b, required Res=%h Rem=%h dbz=%b id=%b",
                   Res, Rem, div_by_zero, done_id, e.res, e.rem, e.dbz, e.id);
        end
      end
    end
  end

  // Waits (bounded) for the requested grant; w = cycles waited, -1 on timeout.
  task automatic wait_gnt(input logic id, output int w);
    w = 0;
    for (int k = 0; k < 60; k++) begin
      #1;
      if ((id == 1'b0 && gnt0 === 1'b1) || (id == 1'b1 && gnt1 === 1'b1)) return;
      @(negedge clk);
      w++;
    end
    w = -1;
  endtask

  // Called just after the grant edge; lat = cycles from grant cycle to done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (done === 1'b1) return;
    end
    lat = -1;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    inp1_0 = '0; inp2_0 = '0; inp1_1 = '0; inp2_1 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || Res !== '0 || Rem !== '0 || done_id !== 1'b0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b Res=%h Rem=%h id=%b dbz=%b, required all 0",
               busy, done, Res, Rem, done_id, div_by_zero);
    end
    req0 = 1'b1; inp1_0 = 16'd100; inp2_0 = 16'd7;
    #1;
    checks++;
    if (gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL gnt_in_reset: got gnt0=%b, required 0", gnt0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL first_grant: got gnt0=%b gnt1=%b, required 1 0", gnt0, gnt1);
    end
    sb.push_back(model(16'd100, 16'd7, 1'b0));
    @(posedge clk);
    #1 req0 = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles, required 17", lat);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || Res !== 16'd14 || Rem !== 16'd2) begin
      errors++;
      $display("FAIL hold_after_done: got done=%b busy=%b Res=%h Rem=%h, required 0 0 000e 0002",
               done, busy, Res, Rem);
    end
  endtask

  task automatic test_div_by_zero();
    int w;
    int lat;
    @(negedge clk);
    req1 = 1'b1; inp1_1 = 16'h1234; inp2_1 = 16'h0000;
    wait_gnt(1'b1, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL dbz_grant_wait: got %0d cycles, required 0", w);
    end
    sb.push_back(model(16'h1234, 16'h0000, 1'b1));
    @(posedge clk);
    #1 req1 = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL dbz_latency: got %0d cycles, required 1", lat);
    end
  endtask

  // Back-to-back operations: each new request is granted in the IDLE cycle after done.
  task automatic test_back_to_back();
    logic [N-1:0] ta[8];
    logic [N-1:0] tb[8];
    int w;
    int lat;
    logic id;
    ta = '{16'hFFFF, 16'd5, 16'd0, 16'hFFFF, 16'd1000, 16'h8000, 16'd0, 16'd0};
    tb = '{16'd1, 16'd9, 16'd5, 16'hFFFF, 16'd0, 16'd3, 16'd0, 16'd0};
    for (int i = 6; i < 8; i++) begin
      ta[i] = 16'($urandom);
      tb[i] = 16'($urandom_range(1, 65535));
    end
    for (int i = 0; i < 8; i++) begin
      id = 1'(i % 2);
      @(negedge clk);
      if (id == 1'b0) begin
        req0 = 1'b1; inp1_0 = ta[i]; inp2_0 = tb[i];
      end else begin
        req1 = 1'b1; inp1_1 = ta[i]; inp2_1 = tb[i];
      end
      wait_gnt(id, w);
      checks++;
      if (w !== 0) begin
        errors++;
        $display("FAIL b2b_grant_wait[%0d]: got %0d cycles, required 0", i, w);
      end
      sb.push_back(model(ta[i], tb[i], id));
      @(posedge clk);
      #1;
      req0 = 1'b0; req1 = 1'b0;
      wait_done(lat);
      checks++;
      if (lat !== ((tb[i] == '0) ? 1 : 17)) begin
        errors++;
        $display("FAIL b2b_latency[%0d]: got %0d cycles, required %0d", i, lat,
                 (tb[i] == '0) ? 1 : 17);
      end
    end
  endtask

  task automatic test_round_robin();
    int lat;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    // Both requesters assert together twice; requester 1 stays high throughout.
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      req0 = 1'b1; inp1_0 = 16'd77 + 16'(pass); inp2_0 = 16'd5;
      req1 = 1'b1; inp1_1 = 16'd900 + 16'(pass); inp2_1 = 16'd11;
      #1;
      checks++;
      if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL rr_pair%0d_first: got gnt0=%b gnt1=%b, required 1 0", pass, gnt0, gnt1);
      end
      sb.push_back(model(16'd77 + 16'(pass), 16'd5, 1'b0));
      @(posedge clk);
      #1 req0 = 1'b0;
      wait_done(lat);
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("FAIL rr_pair%0d_lat0: got %0d cycles, required 17", pass, lat);
      end
      @(negedge clk);
      #1;
      checks++;
      if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
        errors++;
        $display("FAIL rr_pair%0d_second: got gnt0=%b gnt1=%b, required 0 1", pass, gnt0, gnt1);
      end
      sb.push_back(model(16'd900 + 16'(pass), 16'd11, 1'b1));
      @(posedge clk);
      #1 req1 = 1'b0;
      wait_done(lat);
      checks++;
      if (lat !== 17) begin
        errors++;
        $display("FAIL rr_pair%0d_lat1: got %0d cycles, required 17", pass, lat);
      end
    end
  endtask

  task automatic test_busy_ignore();
    int w;
    int lat;
    bit early;
    @(negedge clk);
    req0 = 1'b1; inp1_0 = 16'd5000; inp2_0 = 16'd13;
    wait_gnt(1'b0, w);
    sb.push_back(model(16'd5000, 16'd13, 1'b0));
    @(posedge clk);
    #1;
    req0 = 1'b0;
    req1 = 1'b1; inp1_1 = 16'd4321; inp2_1 = 16'd100;
    early = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      #1;
      if (gnt1 !== 1'b0) early = 1'b1;
      if (done === 1'b1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (early || lat !== 17) begin
      errors++;
      $display("FAIL busy_ignore: got early_gnt1=%b latency=%0d, required 0 and 17", early, lat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (gnt1 !== 1'b1) begin
      errors++;
      $display("FAIL busy_pending_gnt: got gnt1=%b, required 1", gnt1);
    end
    sb.push_back(model(16'd4321, 16'd100, 1'b1));
    @(posedge clk);
    #1;
    checks++;
    if (gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL gnt_one_cycle: got gnt1=%b with req1 held, required 0", gnt1);
    end
    req1 = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL busy_pending_lat: got %0d cycles, required 17", lat);
    end
  endtask

  task automatic test_reset_mid_calc();
    int w;
    int lat;
    bit saw_done;
    @(negedge clk);
    req0 = 1'b1; inp1_0 = 16'd1000; inp2_0 = 16'd3;
    wait_gnt(1'b0, w);
    sb.push_back(model(16'd1000, 16'd3, 1'b0));
    @(posedge clk);
    #1 req0 = 1'b0;
    repeat (8) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Res !== '0 || Rem !== '0 || busy !== 1'b0 || done !== 1'b0 || done_id !== 1'b0 ||
        div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got Res=%h Rem=%h busy=%b done=%b id=%b dbz=%b, required all 0",
               Res, Rem, busy, done, done_id, div_by_zero);
    end
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL discarded_op: got done after reset, required none");
    end
    req0 = 1'b1; inp1_0 = 16'd1000; inp2_0 = 16'd3;
    wait_gnt(1'b0, w);
    checks++;
    if (w !== 0) begin
      errors++;
      $display("FAIL post_reset_grant: got %0d cycles wait, required 0", w);
    end
    sb.push_back(model(16'd1000, 16'd3, 1'b0));
    @(posedge clk);
    #1 req0 = 1'b0;
    wait_done(lat);
    checks++;
    if (lat !== 17) begin
      errors++;
      $display("FAIL post_reset_lat: got %0d cycles, required 17", lat);
    end
  endtask

  initial begin
    test_reset();
    test_div_by_zero();
    test_back_to_back();
    test_round_robin();
    test_busy_ignore();
    test_reset_mid_calc();
    repeat (2) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
